// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: divider FSM states, iteration count and the
// destination tag width also used by the EXE/WB register.
package exe_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = DIV_WIDTH;
    localparam int RD_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] diff;

    // The WIDTH+1-bit trial subtract is split: the bit shifted out of rem_i
    // alone guarantees a non-negative result, otherwise compare the low WIDTH bits.
    assign low   = {rem_i[WIDTH-2:0], bit_i};
    assign diff  = low - divisor_i;
    assign q_o   = rem_i[WIDTH-1] | (low >= divisor_i);
    assign rem_o = q_o ? diff : low;

endmodule

// File: rtl/div_unit_exe.sv
// Iterative signed/unsigned divider for the EXE stage: one quotient bit per
// cycle, result and destination tag presented for a single cycle on done.
module div_unit_exe #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             rem_sel,
    input  logic [RD_W-1:0]  in_Rd,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [RD_W-1:0]  out_Rd,
    output logic [WIDTH-1:0] div_exe
);

    import exe_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             sel_q, sel_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic             done_q, done_d;
    logic [RD_W-1:0]  out_rd_q, out_rd_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign dvd_mag = (signed_op && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
    assign dvs_mag = (signed_op && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;

    // quo_q doubles as the dividend shift register: its MSB feeds each step
    // while the new quotient bit enters at the LSB.
    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            sel_q    <= 1'b0;
            rd_q     <= '0;
            done_q   <= 1'b0;
            out_rd_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            sel_q    <= sel_d;
            rd_q     <= rd_d;
            done_q   <= done_d;
            out_rd_q <= out_rd_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        sel_d    = sel_q;
        rd_d     = rd_q;
        done_d   = 1'b0;
        out_rd_d = out_rd_q;
        res_d    = res_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rd_d   = in_Rd;
                    sel_d  = rem_sel;
                    dvs_d  = dvs_mag;
                    negr_d = signed_op & dividend[WIDTH-1];
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        // Divide by zero: quotient stays all ones, remainder is the dividend.
                        quo_d   = '1;
                        rem_d   = dvd_mag;
                        negq_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        quo_d   = dvd_mag;
                        rem_d   = '0;
                        negq_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                out_rd_d = rd_q;
                if (sel_q) begin
                    res_d = negr_q ? ('0 - rem_q) : rem_q;
                end else begin
                    res_d = negq_q ? ('0 - quo_q) : quo_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign out_Rd  = out_rd_q;
    assign div_exe = res_q;

endmodule

// File: tb/tb_div_unit_exe.sv
// Directed self-checking bench for div_unit_exe: a vector table of single
// operations plus hand sequences for ignored starts, mid-op reset and back-to-back.
module tb_div_unit_exe;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic        rem_sel;
    logic [3:0]  in_Rd;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [3:0]  out_Rd;
    logic [31:0] div_exe;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        sgn;
        logic        rsel;
        logic [3:0]  rd;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    div_unit_exe #(
        .WIDTH(32),
        .RD_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .rem_sel   (rem_sel),
        .in_Rd     (in_Rd),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .out_Rd    (out_Rd),
        .div_exe   (div_exe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call at a negedge; the op is accepted at the following posedge.
    task automatic do_op(input vec_t v, input string name);
        int edges;
        bit seen;
        signed_op = v.sgn;
        rem_sel   = v.rsel;
        in_Rd     = v.rd;
        dividend  = v.dvd;
        divisor   = v.dvs;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, " latency"}, edges, v.exp_lat);
        check({name, " result"}, div_exe, v.exp_res);
        check({name, " out_Rd"}, {28'd0, out_Rd}, {28'd0, v.rd});
        @(negedge clk);
        check({name, " done width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dcount;
        int t_first;
        int t_prev;
        int gap_bad;
        logic [3:0]  cap_rd;
        logic [31:0] cap_res;

        vecs[0]  = '{1'b0, 1'b0, 4'd5,  32'd100,      32'd7,        32'd14,       33};
        vecs[1]  = '{1'b0, 1'b1, 4'd5,  32'd100,      32'd7,        32'd2,        33};
        vecs[2]  = '{1'b1, 1'b0, 4'd3,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33};
        vecs[3]  = '{1'b1, 1'b1, 4'd3,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33};
        vecs[4]  = '{1'b1, 1'b0, 4'd9,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[5]  = '{1'b1, 1'b1, 4'd9,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[6]  = '{1'b0, 1'b0, 4'd7,  32'h00001234, 32'd0,        32'hFFFFFFFF, 1};
        vecs[7]  = '{1'b0, 1'b1, 4'd7,  32'h00001234, 32'd0,        32'h00001234, 1};
        vecs[8]  = '{1'b1, 1'b1, 4'd2,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};
        vecs[9]  = '{1'b1, 1'b0, 4'd2,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1};
        vecs[10] = '{1'b0, 1'b0, 4'd15, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
        vecs[11] = '{1'b0, 1'b0, 4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33};
        vecs[12] = '{1'b0, 1'b1, 4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        33};
        vecs[13] = '{1'b1, 1'b0, 4'd4,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
        vecs[14] = '{1'b1, 1'b1, 4'd4,  32'd100,      32'hFFFFFFF9, 32'd2,        33};
        vecs[15] = '{1'b0, 1'b0, 4'd8,  32'd7,        32'd100,      32'd0,        33};
        vecs[16] = '{1'b0, 1'b1, 4'd8,  32'd7,        32'd100,      32'd7,        33};
        vecs[17] = '{1'b0, 1'b0, 4'd6,  32'h80000000, 32'd3,        32'h2AAAAAAA, 33};
        vecs[18] = '{1'b0, 1'b1, 4'd6,  32'h80000000, 32'd3,        32'd2,        33};
        vecs[19] = '{1'b1, 1'b0, 4'd1,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       33};

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; rem_sel = 1'b0;
        in_Rd = '0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset busy",    {31'd0, busy}, 32'd0);
        check("reset done",    {31'd0, done}, 32'd0);
        check("reset out_Rd",  {28'd0, out_Rd}, 32'd0);
        check("reset div_exe", div_exe, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        repeat (3) @(negedge clk);
        check("hold div_exe", div_exe, 32'h0000000E);
        check("hold out_Rd",  {28'd0, out_Rd}, 32'd1);

        // start pulses during CALC (edges 5, 20) and in the DONE cycle (edge 33)
        signed_op = 1'b0; rem_sel = 1'b0; in_Rd = 4'd5;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk);
        dcount = 0; t_first = -1; cap_rd = '0; cap_res = '0;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (t_first < 0) begin
                    t_first = i - 1;
                    cap_rd  = out_Rd;
                    cap_res = div_exe;
                end
            end
            if (i == 5 || i == 20 || i == 33) begin
                start = 1'b1; in_Rd = 4'd9; dividend = 32'd1000; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ignore done count", dcount, 32'd1);
        check("ignore latency",    t_first, 32'd33);
        check("ignore out_Rd",     {28'd0, cap_rd}, 32'd5);
        check("ignore result",     cap_res, 32'd14);

        // reset asserted mid-CALC
        @(negedge clk);
        signed_op = 1'b0; rem_sel = 1'b0; in_Rd = 4'd5;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy",    {31'd0, busy}, 32'd0);
        check("midrst done",    {31'd0, done}, 32'd0);
        check("midrst out_Rd",  {28'd0, out_Rd}, 32'd0);
        check("midrst div_exe", div_exe, 32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcount++;
            if (i == 2) rst = 1'b0;
        end
        check("midrst no done", dcount, 32'd0);
        do_op('{1'b0, 1'b0, 4'd2, 32'd1, 32'd1, 32'd1, 33}, "after reset");

        // back-to-back with start held high
        @(negedge clk);
        signed_op = 1'b0; rem_sel = 1'b1; in_Rd = 4'd11;
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        dcount = 0; t_first = -1; t_prev = -1; gap_bad = 0; cap_res = '0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                cap_res = div_exe;
                if (t_first < 0) t_first = i - 1;
                else if ((i - 1) - t_prev != 34) gap_bad++;
                t_prev = i - 1;
            end
        end
        start = 1'b0;
        check("b2b done count",   dcount, 32'd3);
        check("b2b first done",   t_first, 32'd33);
        check("b2b spacing",      gap_bad, 32'd0);
        check("b2b result",       cap_res, 32'd1);
        check("b2b out_Rd",       {28'd0, out_Rd}, 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
